// File: rtl/utmi_pkg.sv
// Shared types and defaults for the UTMI transmit path: FSM states,
// line-state encodings {dp, dm} and default parameter values.
package utmi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP_SE0,
    EOP_J
  } tx_state_e;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_SYNC_LEN     = 8;
  localparam int DEF_EOP_SE0_BITS = 2;
  localparam int DEF_STUFF_LIMIT  = 6;

endpackage

// File: rtl/utmi_nrzi_stuffer.sv
// NRZI line encoder with bit stuffing: registers the line level, counts
// consecutive ones and flags when the next line bit must be a stuffed zero.
module utmi_nrzi_stuffer
  import utmi_pkg::*;
#(
  parameter int STUFF_LIMIT = DEF_STUFF_LIMIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pkt_start,
  input  logic bit_in,
  input  logic bit_valid,
  input  logic force_se0,
  input  logic force_j,
  output logic dp,
  output logic dm,
  output logic stuff_pending
);

  localparam int CW = $clog2(STUFF_LIMIT + 1);

  logic [CW-1:0] ones_reg, ones_next;
  logic          nrzi_reg, nrzi_next;  // 1 = J, 0 = K
  logic          se0_reg, se0_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_reg <= '0;
      nrzi_reg <= 1'b1;
      se0_reg  <= 1'b0;
    end else begin
      ones_reg <= ones_next;
      nrzi_reg <= nrzi_next;
      se0_reg  <= se0_next;
    end
  end

  // The bit now on the line completed a run of ones, so the next one is a stuff.
  assign stuff_pending = (ones_reg == CW'(STUFF_LIMIT));

  always_comb begin
    ones_next = ones_reg;
    nrzi_next = nrzi_reg;
    se0_next  = se0_reg;
    if (force_se0) begin
      se0_next  = 1'b1;
      ones_next = '0;
    end else if (force_j) begin
      se0_next  = 1'b0;
      nrzi_next = 1'b1;
      ones_next = '0;
    end else if (pkt_start) begin
      // Reference level is J, so a leading 0 toggles to K and a 1 holds J.
      se0_next  = 1'b0;
      nrzi_next = bit_in;
      ones_next = CW'(bit_in);
    end else if (stuff_pending) begin
      nrzi_next = ~nrzi_reg;
      ones_next = '0;
    end else if (bit_valid) begin
      nrzi_next = bit_in ? nrzi_reg : ~nrzi_reg;
      ones_next = bit_in ? ones_reg + CW'(1) : '0;
    end
  end

  always_comb begin
    if (se0_reg) begin
      {dp, dm} = LINE_SE0;
    end else if (nrzi_reg) begin
      {dp, dm} = LINE_J;
    end else begin
      {dp, dm} = LINE_K;
    end
  end

endmodule

// File: rtl/utmi_tx_serializer.sv
// UTMI transmit serializer: accepts 8/16-bit words under TX_Valid/TX_Ready and
// sends SYNC, bit-stuffed NRZI data and EOP at one line bit per clock.
module utmi_tx_serializer
  import utmi_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int SYNC_LEN     = DEF_SYNC_LEN,
  parameter int EOP_SE0_BITS = DEF_EOP_SE0_BITS,
  parameter int STUFF_LIMIT  = DEF_STUFF_LIMIT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  TX_Valid,
  input  logic                  TX_ValidH,
  input  logic [DATA_WIDTH-1:0] DataIn,
  output logic                  TX_Ready,
  output logic                  TX_DP,
  output logic                  TX_DM,
  output logic                  TX_en
);

  localparam int MAX_LEN = (SYNC_LEN > DATA_WIDTH) ? SYNC_LEN : DATA_WIDTH;
  localparam int BCW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [BCW-1:0] SYNC_LAST = BCW'(SYNC_LEN - 1);
  localparam logic [BCW-1:0] BYTE_LAST = BCW'(7);
  localparam logic [BCW-1:0] WORD_LAST = BCW'(DATA_WIDTH - 1);

  tx_state_e             state_reg, state_next;
  logic [BCW-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                  wide_reg, wide_next;
  logic [2:0]            eop_cnt_reg, eop_cnt_next;

  logic pkt_start, bit_in, bit_valid, force_se0, force_j;
  logic stuff_pending, at_last, load_wide;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      wide_reg    <= 1'b0;
      eop_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      wide_reg    <= wide_next;
      eop_cnt_reg <= eop_cnt_next;
    end
  end

  assign load_wide = (DATA_WIDTH == 16) && TX_ValidH;
  assign at_last   = ((state_reg == SYNC) && (bit_cnt_reg == SYNC_LAST)) ||
                     ((state_reg == DATA) &&
                      (bit_cnt_reg == (wide_reg ? WORD_LAST : BYTE_LAST)));
  // While a stuff bit is pending the last bit's boundary slides onto the stuff cycle.
  assign TX_Ready  = at_last && !stuff_pending;
  assign TX_en     = (state_reg != IDLE);

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    wide_next    = wide_reg;
    eop_cnt_next = eop_cnt_reg;
    pkt_start    = 1'b0;
    bit_in       = 1'b0;
    bit_valid    = 1'b0;
    force_se0    = 1'b0;
    force_j      = 1'b0;
    case (state_reg)
      IDLE: begin
        force_j = !TX_Valid;
        if (TX_Valid) begin
          state_next   = SYNC;
          bit_cnt_next = '0;
          pkt_start    = 1'b1;
          bit_in       = (SYNC_LEN == 1);
        end
      end
      SYNC, DATA: begin
        if (TX_Ready) begin
          if (TX_Valid) begin
            state_next   = DATA;
            shift_next   = DataIn;
            wide_next    = load_wide;
            bit_cnt_next = '0;
            bit_in       = DataIn[0];
            bit_valid    = 1'b1;
          end else begin
            state_next   = EOP_SE0;
            eop_cnt_next = '0;
            force_se0    = 1'b1;
          end
        end else if (!stuff_pending) begin
          bit_cnt_next = bit_cnt_reg + BCW'(1);
          bit_valid    = 1'b1;
          if (state_reg == SYNC) begin
            bit_in = ((bit_cnt_reg + BCW'(1)) == SYNC_LAST);
          end else begin
            shift_next = shift_reg >> 1;
            bit_in     = shift_reg[1];
          end
        end
      end
      EOP_SE0: begin
        if (eop_cnt_reg == 3'(EOP_SE0_BITS - 1)) begin
          state_next = EOP_J;
          force_j    = 1'b1;
        end else begin
          eop_cnt_next = eop_cnt_reg + 3'd1;
          force_se0    = 1'b1;
        end
      end
      EOP_J: begin
        state_next = IDLE;
        force_j    = 1'b1;
      end
      default: begin
        state_next = IDLE;
        force_j    = 1'b1;
      end
    endcase
  end

  utmi_nrzi_stuffer #(
    .STUFF_LIMIT(STUFF_LIMIT)
  ) u_stuffer (
    .clk          (CLK),
    .rst_n        (RST),
    .pkt_start    (pkt_start),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .force_se0    (force_se0),
    .force_j      (force_j),
    .dp           (TX_DP),
    .dm           (TX_DM),
    .stuff_pending(stuff_pending)
  );

endmodule
